// File: rtl/uart_rx_deframer.sv
// UART receive deframer: times mid-bit samples from the start pulse, assembles an
// LSB-first word and reports either a good frame or a framing error.
module uart_rx_deframer #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst_n,
    input  logic                 rx_start,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF  = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (rx_start) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line already back high at mid start bit was a glitch.
                    state_d = rx_serial ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_serial, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BLAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_serial) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = err_q;
    assign rx_busy      = busy_q;

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side UART deframer, directly downstream of the falling-edge detector on the RX line.
- Consumes the detector's one-cycle start pulse and the already-synchronised serial line.
- Times mid-bit sampling with an internal clock-per-bit counter and assembles an LSB-first data word.
- Validates the stop bit, then emits a one-cycle data-valid or framing-error strobe to the RX buffer.

Parameters:
- CLK_DIV, 16, rx_clk cycles per bit; must be even and >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- rx_clk  input  1  block clock; all logic on rising edge.
- rx_rst_n  input  1  synchronous, active-low reset.
- rx_start  input  1  one-cycle falling-edge pulse from the negedge detector.
- rx_serial  input  1  synchronised serial line; idle high.
- rx_data  output  DATA_BITS  last correctly framed word.
- rx_valid  output  1  one-cycle strobe; rx_data updated this cycle.
- rx_frame_err  output  1  one-cycle strobe; stop bit sampled low.
- rx_busy  output  1  high while a frame is in progress.

Behaviour:
- Clock and reset (already decided): one clock, rx_clk; reset rx_rst_n is synchronous and active-low.
- Reset: sampled on the rx_clk rising edge while rx_rst_n = 0.
  - State -> IDLE; bit counter, cycle counter and shift register -> 0.
  - rx_data = 0, rx_valid = 0, rx_frame_err = 0, rx_busy = 0.
  - Reset mid-frame discards the partial word with no strobes; the next rx_start after release is honoured.
- Derived constants:
  - HALF = CLK_DIV/2 - 1.
  - Cycle counter width = clog2(CLK_DIV).
  - Bit counter counts 0..DATA_BITS-1.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: at an edge with rx_start = 1 -> START, cnt <= 0. rx_serial is ignored in IDLE.
  - START: cnt increments each edge.
    - At the edge where cnt == HALF, sample rx_serial.
    - Sample 0 -> DATA, cnt <= 0, bitcnt <= 0.
    - Sample 1 (false start / glitch) -> IDLE, no strobe.
  - DATA: cnt increments.
    - At the edge where cnt == CLK_DIV-1, shift rx_serial in as the next bit, LSB first, and set cnt <= 0.
    - After bit DATA_BITS-1 -> STOP; otherwise bitcnt increments.
  - STOP: at the edge where cnt == CLK_DIV-1, sample rx_serial, then -> IDLE.
    - Sample 1: rx_data <= shift register; rx_valid = 1 for exactly the following cycle.
    - Sample 0: rx_frame_err = 1 for exactly the following cycle; rx_data unchanged.
- Timing, with E0 = the edge that accepts rx_start:
  - Start sample at E0 + HALF + 1.
  - Data bit k sampled at E0 + HALF + 1 + (k+1)*CLK_DIV.
  - Stop sample at E0 + HALF + 1 + (DATA_BITS+1)*CLK_DIV.
  - Defaults: stop sample at E0 + 152; rx_valid is visible in the cycle after that edge.
- rx_busy = 1 whenever state != IDLE, registered with the state.
- rx_start while state != IDLE is ignored; no re-arm and no error.
- Back-to-back frames: the FSM is in IDLE in the cycle rx_valid/rx_frame_err is high, so an rx_start in that same cycle is accepted.
- rx_valid and rx_frame_err are never high together.
- rx_data holds its value until the next good frame.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset and idle:
  - Stimulus: hold rx_rst_n = 0 for 2 cycles with rx_serial = 1, then release; no rx_start for 200 cycles.
  - Required: all outputs 0 throughout.
- Good frame:
  - Stimulus: defaults, drive 0xA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1), 16 cycles/bit, with rx_start pulsed at the falling edge.
  - Required: rx_valid high exactly 1 cycle, after stop sample at E0 + 152; rx_data = 8'hA5; rx_busy high from E0+1 until the stop sample.
- Framing error:
  - Stimulus: same frame with 0x3C and stop bit 0.
  - Required: rx_frame_err 1 cycle; rx_valid stays 0; rx_data keeps 0xA5.
- False start:
  - Stimulus: rx_start pulse with rx_serial low only 3 cycles.
  - Required: return to IDLE at E0 + 8; no strobes; rx_busy high for 8 cycles only.
- Back-to-back frames and ignored start:
  - Stimulus: 0x00 followed immediately by 0xFF, with an extra rx_start injected mid-frame.
  - Required: two rx_valid strobes with data 0x00 then 0xFF; the extra pulse has no effect.
- Reset mid-frame and small-divider build:
  - Stimulus: assert rx_rst_n = 0 during DATA bit 4, release, then send 0x5A.
  - Required: no strobe for the aborted frame; 0x5A received correctly.
  - Repeat the whole test set with CLK_DIV = 4 and DATA_BITS = 7.
